// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty thresholds
// and, when FIFO_ERR_FLAGS_EN is defined, sticky overflow/underflow error flags.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       r_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data_out;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Flags depend only on the count register, never on the request inputs.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wr_ok = w_en && !w_full;
  assign w_rd_ok = r_en && !w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_out     = r_data_out;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A set in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (r_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags (WIDTH=8, DEPTH=16, AF=14, AE=2); error-flag
// expectations follow FIFO_ERR_FLAGS_EN.
module tb_sync_fifo_flags;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       w_en;
  logic [7:0] data_in;
  logic       r_en;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       err_clr;

  int n_vec = 0;
  int n_err = 0;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of stimulus, then sample #1 after the rising edge.
  task automatic cyc(input logic we, input logic [7:0] d, input logic re, input logic clr);
    w_en = we; data_in = d; r_en = re; err_clr = clr;
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; w_en = 0; r_en = 0; err_clr = 0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL por_count got %0d want 0", count); end
    n_vec++; if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      n_err++; $display("FAIL por_flags got e=%b ae=%b f=%b af=%b want 1 1 0 0", empty, almost_empty, full, almost_full); end
    n_vec++; if (data_out !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_err++; $display("FAIL por_misc got dout=%h ovf=%b udf=%b want 00 0 0", data_out, overflow, underflow); end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    n_vec++; if (count !== 5'd5 || data_out !== 8'hC1) begin
      n_err++; $display("FAIL pre_rst got cnt=%0d dout=%h want 5 c1", count, data_out); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (count !== 5'd0 || data_out !== 8'h00) begin
      n_err++; $display("FAIL async_rst got cnt=%0d dout=%h want 0 00", count, data_out); end
    n_vec++; if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0) begin
      n_err++; $display("FAIL async_rst_flags got e=%b ae=%b f=%b want 1 1 0", empty, almost_empty, full); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      n_vec++; if (count !== 5'(i) || almost_full !== (i >= 14) || full !== (i == 16) || almost_empty !== (i <= 2)) begin
        n_err++; $display("FAIL fill[%0d] got cnt=%0d af=%b f=%b ae=%b want %0d %b %b %b",
                          i, count, almost_full, full, almost_empty, i, i >= 14, i == 16, i <= 2); end
    end
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++; if (data_out !== 8'(i) || count !== 5'(16 - i) || empty !== (i == 16) ||
                   almost_empty !== ((16 - i) <= 2) || full !== 1'b0) begin
        n_err++; $display("FAIL drain[%0d] got dout=%h cnt=%0d e=%b ae=%b f=%b want %h %0d %b %b 0",
                          i, data_out, count, empty, almost_empty, full, i, 16 - i, i == 16, (16 - i) <= 2); end
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    n_vec++; if (count !== 5'd16 || full !== 1'b1 || overflow !== ERR_EN) begin
      n_err++; $display("FAIL ovf_set got cnt=%0d f=%b ovf=%b want 16 1 %b", count, full, overflow, ERR_EN); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    n_vec++; if (overflow !== ERR_EN) begin
      n_err++; $display("FAIL ovf_sticky got %b want %b", overflow, ERR_EN); end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    n_vec++; if (overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_clr got %b want 0", overflow); end
    cyc(1'b1, 8'hAA, 1'b0, 1'b1);
    n_vec++; if (overflow !== ERR_EN) begin
      n_err++; $display("FAIL ovf_set_wins got %b want %b", overflow, ERR_EN); end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++; if (data_out !== 8'h31 + 8'(i)) begin
        n_err++; $display("FAIL ovf_drain[%0d] got %h want %h", i, data_out, 8'h31 + 8'(i)); end
    end
    n_vec++; if (empty !== 1'b1 || overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_end got e=%b ovf=%b want 1 0", empty, overflow); end
  endtask

  task automatic test_underflow;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    n_vec++; if (data_out !== 8'h40 || count !== 5'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL udf_data got dout=%h cnt=%0d e=%b want 40 0 1", data_out, count, empty); end
    n_vec++; if (underflow !== ERR_EN || overflow !== 1'b0) begin
      n_err++; $display("FAIL udf_set got udf=%b ovf=%b want %b 0", underflow, overflow, ERR_EN); end
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    n_vec++; if (count !== 5'd1 || data_out !== 8'h40 || underflow !== ERR_EN) begin
      n_err++; $display("FAIL udf_wr_same got cnt=%0d dout=%h udf=%b want 1 40 %b", count, data_out, underflow, ERR_EN); end
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    n_vec++; if (underflow !== 1'b0 || data_out !== 8'h77 || count !== 5'd0) begin
      n_err++; $display("FAIL udf_clr got udf=%b dout=%h cnt=%0d want 0 77 0", underflow, data_out, count); end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 8'h56 + 8'(k), 1'b1, 1'b0);
      n_vec++; if (count !== 5'd5 || data_out !== 8'h51 + 8'(k) || empty !== 1'b0 || almost_empty !== 1'b0) begin
        n_err++; $display("FAIL sim5[%0d] got cnt=%0d dout=%h want 5 %h", k, count, data_out, 8'h51 + 8'(k)); end
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++; if (data_out !== 8'h55 + 8'(k)) begin
        n_err++; $display("FAIL sim5_drain[%0d] got %h want %h", k, data_out, 8'h55 + 8'(k)); end
    end
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h61 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hBB, 1'b1, 1'b0);
    n_vec++; if (count !== 5'd15 || full !== 1'b0 || data_out !== 8'h61 || overflow !== ERR_EN) begin
      n_err++; $display("FAIL sim16 got cnt=%0d f=%b dout=%h ovf=%b want 15 0 61 %b", count, full, data_out, overflow, ERR_EN); end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 15; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++; if (data_out !== 8'h62 + 8'(k)) begin
        n_err++; $display("FAIL sim16_drain[%0d] got %h want %h", k, data_out, 8'h62 + 8'(k)); end
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL sim16_empty got %b want 1", empty); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++; if (data_out !== 8'h90 + 8'(i)) begin
        n_err++; $display("FAIL wrap_pre[%0d] got %h want %h", i, data_out, 8'h90 + 8'(i)); end
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      n_vec++; if (full !== (i == 15) || empty !== 1'b0) begin
        n_err++; $display("FAIL wrap_fill[%0d] got f=%b e=%b want %b 0", i, full, empty, i == 15); end
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++; if (data_out !== 8'h20 + 8'(i) || empty !== (i == 15) || full !== 1'b0) begin
        n_err++; $display("FAIL wrap_drain[%0d] got dout=%h e=%b f=%b want %h %b 0",
                          i, data_out, empty, full, 8'h20 + 8'(i), i == 15); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO that supersedes the fixed 8×8 synchronous FIFO. It buffers WIDTH-bit words between a producer and a consumer in the same clock domain. It adds an occupancy count, programmable almost-full/almost-empty thresholds and optional sticky overflow/underflow error flags. Intended as the common buffering primitive for streaming datapaths in the design.

## Interface
- WIDTH, 8: data word width in bits (≥1).
- DEPTH, 16: number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1).
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- w_en  in  1  write request.
- data_in  in  WIDTH  write data, sampled on clk rise when write accepted.
- r_en  in  1  read request.
- data_out  out  WIDTH  registered read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full (see Configuration).
- underflow  out  1  sticky: read attempted while empty (see Configuration).
- err_clr  in  1  synchronous clear of overflow/underflow.

## Operation
- Storage: DEPTH×WIDTH register array. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. The array is not reset.
- Write accepted (wr_ok) = w_en && !full. On accept: mem[wr_ptr] <= data_in, wr_ptr++.
- Read accepted (rd_ok) = r_en && !empty. On accept: data_out <= mem[rd_ptr], rd_ptr++.
- Acceptance is evaluated on the pre-edge count. A write when full is dropped even if a read is accepted in the same cycle. A read when empty is rejected even if a write is accepted in the same cycle.
- Count update: wr_ok only → +1; rd_ok only → −1; both or neither → unchanged.
- Flags are decoded combinationally from the count register only, so they change on the same edge as count. They have no combinational path from w_en or r_en.
- data_out holds its last value when no read is accepted.
- Reset (asynchronous, any time, including mid-transfer):
  - wr_ptr, rd_ptr, count = 0; data_out = 0.
  - empty = 1; almost_empty = 1 (AE_LEVEL ≥ 0).
  - full = 0, almost_full = 0, overflow = 0, underflow = 0.
  - Data in flight is discarded.

## Timing
- Write-to-read latency: a word written at edge N can be accepted by a read at edge N+1 (empty deasserts after edge N). It appears on data_out after that read edge.
- Read latency: 1 cycle. data_out is valid after the edge at which rd_ok was true.
- full asserts after the edge that raises count to DEPTH. It deasserts after the first edge with rd_ok and no wr_ok.
- A simultaneous accepted read and write at 0 < count < DEPTH leaves count and all flags unchanged.

## Configuration
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any edge with w_en && full.
  - underflow sets on any edge with r_en && empty.
  - Both flags are sticky until an edge with err_clr = 1. If a set and err_clr occur in the same cycle, set wins.
- Undefined: overflow and underflow are tied to 0, err_clr is ignored, and no error logic is synthesised. Port list is identical in both builds.

## Test plan
- Reset: assert reset mid-fill at count 5 → count = 0, empty = 1, almost_empty = 1, full = 0, data_out = 0 without waiting for a clock edge.
- Fill/drain (DEPTH=16): write 0x01..0x10 → almost_full after the 14th write, full after the 16th. Then read 16 → data_out = 0x01..0x10 in order, empty after the 16th read, almost_empty at count ≤ 2.
- Overflow: full FIFO, w_en = 1 with data 0xAA → count stays 16, 0xAA is never read out, overflow = 1 (macro defined). err_clr → overflow = 0. With the macro undefined, overflow stays 0.
- Underflow: empty FIFO, r_en = 1 → data_out unchanged, count = 0, underflow = 1 (macro defined).
- Simultaneous: at count 5, w_en = r_en = 1 for 4 cycles → count stays 5 and read data follows FIFO order. At count 16 with both asserted → read accepted, write dropped, count = 15.
- Wrap-around: write 10, read 10, write 16 (0x20..0x2F), read 16 → exact order 0x20..0x2F across the pointer wrap, with full and empty correct at the extremes.
